// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one memory read per instruction, holds the
// fetched word until downstream accepts it, and handles branch-flush redirects.
module fetch_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic                  pc_inc,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] ir_out,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   output logic [CNT_WIDTH-1:0]  fetch_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   ir_out_q;
   logic                    ir_valid_q;
   logic [CNT_WIDTH-1:0]    fetch_count_q;
   logic [CNT_WIDTH-1:0]    fetch_count_d;

   assign fetch_count_d = fetch_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q       <= IDLE;
         mem_addr_q    <= '0;
         ir_out_q      <= '0;
         ir_valid_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable && !flush) begin
                  mem_addr_q <= pc_in;
                  state_q    <= ISSUE;
               end
            end
            // A response arriving in ISSUE belongs to no request of ours; ignore it.
            ISSUE: state_q <= flush ? IDLE : WAIT;
            WAIT: begin
               if (flush) begin
                  state_q <= mem_ready ? IDLE : DRAIN;
               end else if (mem_ready) begin
                  ir_out_q   <= mem_data;
                  ir_valid_q <= 1'b1;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (flush) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end else if (ir_ready) begin
                  ir_valid_q    <= 1'b0;
                  fetch_count_q <= fetch_count_d;
                  if (enable) begin
                     mem_addr_q <= pc_in;
                     state_q    <= ISSUE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            // The outstanding read must still complete; its data is dropped.
            DRAIN: if (mem_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read    = (state_q == ISSUE) || (state_q == WAIT);
   assign pc_inc      = (state_q == WAIT) && mem_ready && !flush;
   assign mem_addr    = mem_addr_q;
   assign ir_out      = ir_out_q;
   assign ir_valid    = ir_valid_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; delivered instructions are checked by a scoreboard monitor.
module tb_fetch_unit;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 8;   // narrow counter so the wrap case stays short

   logic          clock = 1'b0;
   logic          clear, enable, flush, mem_ready, ir_ready;
   logic [AW-1:0] pc_in, mem_addr;
   logic [DW-1:0] mem_data, ir_out;
   logic          pc_inc, mem_read, ir_valid;
   logic [CW-1:0] fetch_count;

   int            total = 0;
   int            bad = 0;
   int            pc_inc_cnt = 0;
   int            mem_read_cnt = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] sb_exp;
   logic [CW-1:0] exp_cnt = '0;

   fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clock(clock), .clear(clear), .enable(enable), .flush(flush),
      .pc_in(pc_in), .pc_inc(pc_inc), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_ready(mem_ready), .mem_data(mem_data), .ir_out(ir_out),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Monitor: counts strobes and checks every accepted instruction against the queue.
   always @(negedge clock) begin
      if (!clear) begin
         if (pc_inc)   pc_inc_cnt++;
         if (mem_read) mem_read_cnt++;
         if (ir_valid && ir_ready && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got %0h expected none", ir_out);
            end else begin
               sb_exp = exp_q.pop_front();
               if (ir_out !== sb_exp) begin
                  bad++;
                  $display("FAIL sb_ir_out: got %0h expected %0h", ir_out, sb_exp);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] pc);
      pc_in  = pc;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      check("issue_addr", mem_addr, pc);
      check("issue_read", mem_read, 1);
   endtask

   // Starts in ISSUE; runs WAIT (delay empty cycles), HOLD (hold cycles), then accepts.
   task automatic complete(input logic [DW-1:0] data, input int delay, input int hold,
                           input bit chain);
      int rd0, inc0;
      rd0  = mem_read_cnt;
      inc0 = pc_inc_cnt;
      tick();
      check("wait_no_valid", ir_valid, 0);
      repeat (delay) tick();
      check("pc_inc_early", pc_inc_cnt - inc0, 0);
      mem_ready = 1'b1;
      mem_data  = data;
      exp_q.push_back(data);
      tick();
      mem_ready = 1'b0;
      mem_data  = '0;
      check("hold_valid", ir_valid, 1);
      check("hold_ir_out", ir_out, data);
      pc_in = pc_in + 32'd4;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid_stable", ir_valid, 1);
         check("hold_ir_stable", ir_out, data);
      end
      check("mem_read_cycles", mem_read_cnt - rd0, delay + 2);
      check("pc_inc_pulses", pc_inc_cnt - inc0, 1);
      ir_ready = 1'b1;
      enable   = chain;
      tick();
      ir_ready = 1'b0;
      enable   = 1'b0;
      exp_cnt  = exp_cnt + 1'b1;
      check("fetch_count", fetch_count, exp_cnt);
      check("valid_cleared", ir_valid, 0);
      check("read_after_accept", mem_read, chain);
      if (chain) check("chain_addr", mem_addr, pc_in);
   endtask

   initial begin
      int rd0, inc0;
      clear = 1'b1; enable = 1'b0; flush = 1'b0; mem_ready = 1'b0; ir_ready = 1'b0;
      pc_in = '0; mem_data = '0;
      tick(); tick();
      clear = 1'b0;
      check("rst_mem_addr", mem_addr, 0);
      check("rst_ir_out", ir_out, 0);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_fetch_count", fetch_count, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_pc_inc", pc_inc, 0);
      tick(); tick();
      check("idle_mem_read", mem_read, 0);
      check("idle_mem_addr", mem_addr, 0);

      // Zero-wait fetch, slow memory, slow consumer with back-to-back follow-on.
      issue(32'h10);
      complete(32'hDEADBEEF, 0, 0, 1'b0);
      issue(32'h14);
      complete(32'hA5A50001, 3, 0, 1'b0);
      issue(32'h18);
      complete(32'h0BADF00D, 0, 5, 1'b1);
      complete(32'h11112222, 1, 0, 1'b0);

      // Flush in WAIT without response: DRAIN ignores enable and a second flush.
      issue(32'h40);
      inc0 = pc_inc_cnt;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      rd0 = mem_read_cnt;
      check("drain_read", mem_read, 0);
      enable = 1'b1;
      pc_in  = 32'h80;
      tick();
      enable = 1'b0;
      check("drain_holds", mem_read, 0);
      check("drain_addr", mem_addr, 32'h40);
      flush = 1'b1; mem_ready = 1'b1; mem_data = 32'h12345678;
      tick();
      flush = 1'b0; mem_ready = 1'b0; mem_data = '0;
      check("drain_valid", ir_valid, 0);
      check("drain_pc_inc", pc_inc_cnt - inc0, 0);
      check("drain_read_cnt", mem_read_cnt - rd0, 0);
      check("drain_count", fetch_count, exp_cnt);
      issue(32'h44);
      complete(32'h44440000, 0, 0, 1'b0);

      // Flush together with mem_ready in WAIT: straight to IDLE.
      issue(32'h50);
      inc0 = pc_inc_cnt;
      tick();
      mem_ready = 1'b1; mem_data = 32'hCAFEF00D; flush = 1'b1;
      tick();
      mem_ready = 1'b0; mem_data = '0; flush = 1'b0;
      check("fr_valid", ir_valid, 0);
      check("fr_read", mem_read, 0);
      check("fr_pc_inc", pc_inc_cnt - inc0, 0);
      issue(32'h54);
      complete(32'h54545454, 0, 0, 1'b0);

      // Flush in ISSUE, then flush beating enable in IDLE.
      pc_in = 32'h60; enable = 1'b1;
      tick();
      flush = 1'b1; pc_in = 32'h64;
      tick();
      check("fi_read", mem_read, 0);
      check("fi_addr", mem_addr, 32'h60);
      pc_in = 32'h68;
      tick();
      flush = 1'b0; enable = 1'b0;
      check("fidle_read", mem_read, 0);
      check("fidle_addr", mem_addr, 32'h60);

      // Flush in HOLD beats ir_ready and enable.
      issue(32'h70);
      tick();
      mem_ready = 1'b1; mem_data = 32'h77777777;
      tick();
      mem_ready = 1'b0; mem_data = '0;
      check("fh_valid_set", ir_valid, 1);
      flush = 1'b1; ir_ready = 1'b1; enable = 1'b1; pc_in = 32'h74;
      tick();
      flush = 1'b0; ir_ready = 1'b0; enable = 1'b0;
      check("fh_valid", ir_valid, 0);
      check("fh_count", fetch_count, exp_cnt);
      check("fh_read", mem_read, 0);
      check("fh_addr", mem_addr, 32'h70);

      // Counter wrap.
      for (int k = 0; k < 300 && exp_cnt != {CW{1'b1}}; k++) begin
         issue(32'h1000 + 32'(k) * 4);
         complete(32'hF0000000 + 32'(k), 0, 0, 1'b0);
      end
      check("cnt_full", fetch_count, {CW{1'b1}});
      issue(32'h2000);
      complete(32'hABCD0123, 0, 0, 1'b0);
      check("cnt_wrap", fetch_count, 0);
      issue(32'h2004);
      complete(32'hABCD0456, 0, 0, 1'b0);
      check("cnt_after_wrap", fetch_count, 1);

      // Clear in HOLD and in WAIT.
      issue(32'h90);
      tick();
      mem_ready = 1'b1; mem_data = 32'h99999999;
      tick();
      mem_ready = 1'b0; mem_data = '0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      exp_cnt = '0;
      check("clr_mem_addr", mem_addr, 0);
      check("clr_ir_out", ir_out, 0);
      check("clr_ir_valid", ir_valid, 0);
      check("clr_count", fetch_count, 0);
      check("clr_read", mem_read, 0);
      issue(32'hA0);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clrw_read", mem_read, 0);
      mem_ready = 1'b1; mem_data = 32'hBEEFBEEF;
      tick();
      mem_ready = 1'b0; mem_data = '0;
      check("clrw_valid", ir_valid, 0);
      issue(32'hB0);
      complete(32'hB0B0B0B0, 0, 0, 1'b0);

      tick();
      check("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
